// File: rtl/sram_wb_ctrl.sv
// Wishbone-classic slave that runs one 16-bit async SRAM access per bus cycle with programmable wait states.
// Optional address-range error response is enabled by defining SRAM_ERR_EN.
module sram_wb_ctrl #(
    parameter int unsigned AB_WIDTH    = 16,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned ADDR_LIMIT  = 2**16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [AB_WIDTH-1:0] wb_adr_i,
    input  logic [15:0]         wb_dat_i,
    input  logic [1:0]          wb_sel_i,
    output logic [15:0]         wb_dat_o,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic [AB_WIDTH-1:0] sram_addr_o,
    output logic [15:0]         sram_dat_o,
    input  logic [15:0]         sram_dat_i,
    output logic [1:0]          sram_bsel_o,
    output logic                sram_ncs_o,
    output logic                sram_noe_o,
    output logic                sram_nwe_o
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [AB_WIDTH-1:0]   addr_q, addr_d;
    logic [15:0]           wdat_q, wdat_d;
    logic [1:0]            bsel_q, bsel_d;
    logic                  we_q, we_d;
    logic [15:0]           rdat_q, rdat_d;
    logic                  ncs_q, ncs_d;
    logic                  noe_q, noe_d;
    logic                  nwe_q, nwe_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;

    logic req;
    logic addr_err;

    assign req = wb_cyc_i & wb_stb_i;

`ifdef SRAM_ERR_EN
    // Compare in 33 bits so ADDR_LIMIT may equal 2**AB_WIDTH (no address rejected).
    assign addr_err = ({{(33-AB_WIDTH){1'b0}}, wb_adr_i} >= {1'b0, ADDR_LIMIT});
`else
    logic unused_limit;
    assign unused_limit = ^ADDR_LIMIT;
    assign addr_err     = 1'b0;
`endif

    // State register: FSM state, wait counter and every registered output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
            bsel_q  <= '0;
            we_q    <= 1'b0;
            rdat_q  <= '0;
            ncs_q   <= 1'b1;
            noe_q   <= 1'b1;
            nwe_q   <= 1'b1;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            bsel_q  <= bsel_d;
            we_q    <= we_d;
            rdat_q  <= rdat_d;
            ncs_q   <= ncs_d;
            noe_q   <= noe_d;
            nwe_q   <= nwe_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (addr_err) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCESS;
                        cnt_d   = WAIT_LD;
                    end
                end
            end
            S_ACCESS: begin
                if (!wb_cyc_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: pins default to idle, so every exit from ACCESS releases them.
    always_comb begin
        addr_d = addr_q;
        wdat_d = wdat_q;
        bsel_d = bsel_q;
        we_d   = we_q;
        rdat_d = rdat_q;
        ncs_d  = 1'b1;
        noe_d  = 1'b1;
        nwe_d  = 1'b1;
        ack_d  = 1'b0;
        err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (addr_err) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d = wb_adr_i;
                        wdat_d = wb_dat_i;
                        bsel_d = wb_sel_i;
                        we_d   = wb_we_i;
                        ncs_d  = 1'b0;
                        noe_d  = wb_we_i;
                        nwe_d  = ~wb_we_i;
                    end
                end
            end
            S_ACCESS: begin
                if (wb_cyc_i) begin
                    if (cnt_q == 4'd0) begin
                        ack_d = 1'b1;
                        if (!we_q) begin
                            rdat_d = sram_dat_i;
                        end
                    end else begin
                        ncs_d = ncs_q;
                        noe_d = noe_q;
                        nwe_d = nwe_q;
                    end
                end
            end
            default: ;
        endcase
    end

    assign wb_dat_o    = rdat_q;
    assign wb_ack_o    = ack_q;
    assign wb_err_o    = err_q;
    assign sram_addr_o = addr_q;
    assign sram_dat_o  = wdat_q;
    assign sram_bsel_o = bsel_q;
    assign sram_ncs_o  = ncs_q;
    assign sram_noe_o  = noe_q;
    assign sram_nwe_o  = nwe_q;

endmodule

// File: tb/tb_sram_wb_ctrl.sv
// Scoreboard bench for sram_wb_ctrl: channel 0 uses WAIT_CYCLES=0, channel 1 uses WAIT_CYCLES=3,
// each with its own behavioural async SRAM. Error-range cases follow SRAM_ERR_EN.
`timescale 1ns/1ps
module tb_sram_wb_ctrl;

    localparam int AW    = 16;
    localparam int NCH   = 2;
    localparam int W1    = 3;
    localparam int LIMIT = 'h100;

    typedef struct {
        int          ch;
        bit          is_err;
        logic [15:0] dat;
        int          req;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NCH-1:0]         cyc, stb, we, ack, err, ncs, noe, nwe;
    logic [NCH-1:0][AW-1:0] adr, s_addr;
    logic [NCH-1:0][15:0]   wdat, rdat, s_wdat, s_rdat;
    logic [NCH-1:0][1:0]    sel, s_bsel;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [15:0] mem [0:511];

        sram_wb_ctrl #(
            .AB_WIDTH   (AW),
            .WAIT_CYCLES((g == 0) ? 0 : W1),
            .ADDR_LIMIT (LIMIT)
        ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst),
            .wb_cyc_i   (cyc[g]),
            .wb_stb_i   (stb[g]),
            .wb_we_i    (we[g]),
            .wb_adr_i   (adr[g]),
            .wb_dat_i   (wdat[g]),
            .wb_sel_i   (sel[g]),
            .wb_dat_o   (rdat[g]),
            .wb_ack_o   (ack[g]),
            .wb_err_o   (err[g]),
            .sram_addr_o(s_addr[g]),
            .sram_dat_o (s_wdat[g]),
            .sram_dat_i (s_rdat[g]),
            .sram_bsel_o(s_bsel[g]),
            .sram_ncs_o (ncs[g]),
            .sram_noe_o (noe[g]),
            .sram_nwe_o (nwe[g])
        );

        assign s_rdat[g] = (!ncs[g] && !noe[g]) ? mem[s_addr[g][8:0]] : 16'h0000;

        always @(posedge clk) begin
            if (!ncs[g] && !nwe[g]) begin
                if (s_bsel[g][0]) mem[s_addr[g][8:0]][7:0]  <= s_wdat[g][7:0];
                if (s_bsel[g][1]) mem[s_addr[g][8:0]][15:8] <= s_wdat[g][15:8];
            end
        end
    end

    int          cyc_cnt = 0;
    int          n_cmp   = 0;
    int          n_bad   = 0;
    exp_t        sbq[$];
    exp_t        mon_e;
    logic [15:0] last_rd [NCH];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic int wait_of(int c);
        return (c == 0) ? 0 : W1;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bad(string name, string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    // Monitor: pops the scoreboard whenever a channel presents ack or err.
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (!rst) begin
                chk($sformatf("ch%0d noe_nwe_exclusive", c), {31'b0, !noe[c] && !nwe[c]}, 32'd0);
                if (ack[c] || err[c]) begin
                    if (sbq.size() == 0) begin
                        bad($sformatf("ch%0d unexpected_resp", c), "got ack/err, required none");
                    end else begin
                        mon_e = sbq.pop_front();
                        chk($sformatf("ch%0d resp_channel", c), c, mon_e.ch);
                        chk($sformatf("ch%0d err", c), {31'b0, err[c]}, {31'b0, mon_e.is_err});
                        chk($sformatf("ch%0d ack", c), {31'b0, ack[c]}, {31'b0, !mon_e.is_err});
                        chk($sformatf("ch%0d latency", c), cyc_cnt - mon_e.req, mon_e.lat);
                        if (!mon_e.is_err)
                            chk($sformatf("ch%0d wb_dat_o", c), {16'b0, rdat[c]}, {16'b0, mon_e.dat});
                    end
                end
            end
        end
    end

    task automatic start(int c, bit w, logic [15:0] a, logic [15:0] d, logic [1:0] s);
        @(negedge clk);
        cyc[c] = 1'b1; stb[c] = 1'b1; we[c] = w;
        adr[c] = a;    wdat[c] = d;   sel[c] = s;
    endtask

    // One full bus cycle; checks pin values on every cycle ncs is low.
    task automatic xfer(int c, bit w, logic [15:0] a, logic [15:0] d, logic [1:0] s,
                        bit exp_err, logic [15:0] exp_dat);
        exp_t e;
        int   low  = 0;
        bit   done = 1'b0;
        start(c, w, a, d, s);
        e.ch = c; e.is_err = exp_err; e.req = cyc_cnt + 1;
        e.lat = exp_err ? 0 : wait_of(c) + 1;
        e.dat = w ? last_rd[c] : exp_dat;
        sbq.push_back(e);
        if (!w && !exp_err) last_rd[c] = exp_dat;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!ncs[c]) begin
                low++;
                chk($sformatf("ch%0d pin_addr", c), {16'b0, s_addr[c]}, {16'b0, a});
                chk($sformatf("ch%0d pin_bsel", c), {30'b0, s_bsel[c]}, {30'b0, s});
                chk($sformatf("ch%0d pin_noe", c), {31'b0, noe[c]}, {31'b0, w});
                chk($sformatf("ch%0d pin_nwe", c), {31'b0, nwe[c]}, {31'b0, !w});
                if (w) chk($sformatf("ch%0d pin_wdat", c), {16'b0, s_wdat[c]}, {16'b0, d});
            end
            if (ack[c] || err[c]) done = 1'b1;
        end
        if (!done) bad($sformatf("ch%0d timeout", c), "no ack/err in 40 cycles, required one");
        chk($sformatf("ch%0d ncs_low_cycles", c), low, exp_err ? 0 : wait_of(c) + 1);
        cyc[c] = 1'b0;
        stb[c] = 1'b0;
    endtask

    initial begin
        cyc = '0; stb = '0; we = '0; adr = '0; wdat = '0; sel = '0;
        for (int c = 0; c < NCH; c++) last_rd[c] = 16'h0000;

        // Reset held two cycles
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("ch%0d rst_ncs", c), {31'b0, ncs[c]}, 32'd1);
            chk($sformatf("ch%0d rst_noe", c), {31'b0, noe[c]}, 32'd1);
            chk($sformatf("ch%0d rst_nwe", c), {31'b0, nwe[c]}, 32'd1);
            chk($sformatf("ch%0d rst_ack", c), {31'b0, ack[c]}, 32'd0);
            chk($sformatf("ch%0d rst_err", c), {31'b0, err[c]}, 32'd0);
            chk($sformatf("ch%0d rst_dat", c), {16'b0, rdat[c]}, 32'd0);
        end
        rst = 1'b0;

        // Write then read back, zero wait states
        xfer(0, 1'b1, 16'h0012, 16'hA55A, 2'b11, 1'b0, 16'h0000);
        xfer(0, 1'b0, 16'h0012, 16'h0000, 2'b11, 1'b0, 16'hA55A);

        // Byte lanes
        xfer(0, 1'b1, 16'h0040, 16'h1234, 2'b11, 1'b0, 16'h0000);
        xfer(0, 1'b1, 16'h0040, 16'h00FF, 2'b01, 1'b0, 16'h0000);
        xfer(0, 1'b0, 16'h0040, 16'h0000, 2'b11, 1'b0, 16'h12FF);

        // sel=00 write is acked but must not touch memory
        xfer(0, 1'b1, 16'h0012, 16'h0000, 2'b00, 1'b0, 16'h0000);
        xfer(0, 1'b0, 16'h0012, 16'h0000, 2'b11, 1'b0, 16'hA55A);

        // Three wait states
        xfer(1, 1'b1, 16'h0007, 16'hBEEF, 2'b11, 1'b0, 16'h0000);
        xfer(1, 1'b0, 16'h0007, 16'h0000, 2'b11, 1'b0, 16'hBEEF);

        // Abort: drop cyc during the first ACCESS cycle
        start(0, 1'b0, 16'h0040, 16'h0000, 2'b11);
        @(negedge clk);
        chk("abort ncs_active", {31'b0, ncs[0]}, 32'd0);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(negedge clk);
        chk("abort ncs_released", {31'b0, ncs[0]}, 32'd1);
        chk("abort noe_released", {31'b0, noe[0]}, 32'd1);
        xfer(0, 1'b0, 16'h0012, 16'h0000, 2'b11, 1'b0, 16'hA55A);

        // Reset in the middle of a wait-stated access
        start(1, 1'b0, 16'h0007, 16'h0000, 2'b11);
        @(negedge clk);
        chk("rst_mid ncs_active", {31'b0, ncs[1]}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid ncs_released", {31'b0, ncs[1]}, 32'd1);
        chk("rst_mid ack", {31'b0, ack[1]}, 32'd0);
        chk("rst_mid dat", {16'b0, rdat[1]}, 32'd0);
        rst = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
        for (int c = 0; c < NCH; c++) last_rd[c] = 16'h0000;
        xfer(1, 1'b1, 16'h0008, 16'h1111, 2'b11, 1'b0, 16'h0000);
        xfer(1, 1'b0, 16'h0007, 16'h0000, 2'b11, 1'b0, 16'hBEEF);

        // Address range boundary at LIMIT
`ifdef SRAM_ERR_EN
        xfer(0, 1'b1, 16'h0100, 16'h5A5A, 2'b11, 1'b1, 16'h0000);
        xfer(0, 1'b1, 16'h00FF, 16'hC3C3, 2'b11, 1'b0, 16'h0000);
        xfer(0, 1'b0, 16'h0100, 16'h0000, 2'b11, 1'b1, 16'h0000);
        xfer(0, 1'b0, 16'h00FF, 16'h0000, 2'b11, 1'b0, 16'hC3C3);
`else
        xfer(0, 1'b1, 16'h0100, 16'h5A5A, 2'b11, 1'b0, 16'h0000);
        xfer(0, 1'b1, 16'h00FF, 16'hC3C3, 2'b11, 1'b0, 16'h0000);
        xfer(0, 1'b0, 16'h0100, 16'h0000, 2'b11, 1'b0, 16'h5A5A);
        xfer(0, 1'b0, 16'h00FF, 16'h0000, 2'b11, 1'b0, 16'hC3C3);
`endif

        repeat (4) @(negedge clk);
        if (sbq.size() != 0) bad("scoreboard_drain", $sformatf("%0d responses outstanding, required 0", sbq.size()));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
